// File: rtl/easyaxi_rd_mst_pkg.sv
// Shared AXI defines and the burst bundle for the easyaxi read master.
// EASYAXI_RD_DATA_CHK_EN adds the address field used for rdata checking.
`ifndef EASYAXI_AXI_DEFINE
`define EASYAXI_AXI_DEFINE
`define AXI_ID_W        4
`define AXI_ADDR_W      32
`define AXI_DATA_W      64
`define AXI_LEN_W       8
`define AXI_SIZE_W      3
`define AXI_BURST_W     2
`define AXI_RESP_W      2
`define AXI_BURST_INCR  2'b01
`define AXI_RESP_OKAY   2'b00
`define AXI_RESP_SLVERR 2'b10
`endif

package easyaxi_rd_mst_pkg;
  localparam int ID_W    = `AXI_ID_W;
  localparam int ADDR_W  = `AXI_ADDR_W;
  localparam int DATA_W  = `AXI_DATA_W;
  localparam int LEN_W   = `AXI_LEN_W;
  localparam int SIZE_W  = `AXI_SIZE_W;
  localparam int BURST_W = `AXI_BURST_W;
  localparam int RESP_W  = `AXI_RESP_W;

  localparam logic [RESP_W-1:0]  RESP_OKAY  = `AXI_RESP_OKAY;
  localparam logic [BURST_W-1:0] BURST_INCR = `AXI_BURST_INCR;
  localparam logic [SIZE_W-1:0]  SIZE_4B    = SIZE_W'(2);

  typedef struct packed {
`ifdef EASYAXI_RD_DATA_CHK_EN
    logic [ADDR_W-1:0] addr;
`endif
    logic [ID_W-1:0]   id;
    logic [LEN_W-1:0]  len;
  } burst_t;

`ifdef EASYAXI_RD_DATA_CHK_EN
  // Expected beat payload: burst id above the beat address.
  function automatic logic [DATA_W-1:0] beat_data(
    input burst_t           b,
    input logic [LEN_W-1:0] beat
  );
    logic [ID_W+ADDR_W-1:0] v;
    v = {b.id, b.addr + (ADDR_W'(beat) << 2)};
    return DATA_W'(v);
  endfunction
`endif
endpackage

// File: rtl/easyaxi_ost_fifo.sv
// Small synchronous FIFO with full/empty flags and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module easyaxi_ost_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] cnt
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign cnt     = cnt_q;
  assign dout    = mem_q[rp_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    if (push_ok) begin
      mem_d[wp_q] = din;
      wp_d        = wp_q + PW'(1);
    end
    if (pop_ok) begin
      rp_d = rp_q + PW'(1);
    end
    cnt_d = cnt_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/easyaxi_rd_mst.sv
// AXI read master: issues REQ_NUM INCR bursts and checks every R beat.
// EASYAXI_RD_DATA_CHK_EN also checks rdata against {id, addr+beat*4}.
module easyaxi_rd_mst
  import easyaxi_rd_mst_pkg::*;
#(
  parameter int OST_DEPTH = 4,
  parameter int REQ_NUM   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  output logic               axi_mst_arvalid,
  input  logic               axi_mst_arready,
  output logic [ID_W-1:0]    axi_mst_arid,
  output logic [ADDR_W-1:0]  axi_mst_araddr,
  output logic [LEN_W-1:0]   axi_mst_arlen,
  output logic [SIZE_W-1:0]  axi_mst_arsize,
  output logic [BURST_W-1:0] axi_mst_arburst,
  input  logic               axi_mst_rvalid,
  output logic               axi_mst_rready,
  input  logic [ID_W-1:0]    axi_mst_rid,
  input  logic [DATA_W-1:0]  axi_mst_rdata,
  input  logic [RESP_W-1:0]  axi_mst_rresp,
  input  logic               axi_mst_rlast,
  output logic               rd_done,
  output logic               rd_err,
  output logic [7:0]         rd_resp_err_cnt
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int CW = $clog2(REQ_NUM + 1);
  localparam int OW = $clog2(OST_DEPTH) + 1;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      iss_cnt_q, iss_cnt_d;
  logic [CW-1:0]      cmp_cnt_q, cmp_cnt_d;
  logic [LEN_W-1:0]   beat_q, beat_d;
  logic               arvalid_q, arvalid_d;
  logic [ID_W-1:0]    arid_q, arid_d;
  logic [ADDR_W-1:0]  araddr_q, araddr_d;
  logic [LEN_W-1:0]   arlen_q, arlen_d;
  logic [SIZE_W-1:0]  arsize_q, arsize_d;
  logic [BURST_W-1:0] arburst_q, arburst_d;
  logic               err_q, err_d;
  logic [7:0]         rerr_cnt_q, rerr_cnt_d;

  logic          ar_hs, r_hs, pop, bad, issue_ok;
  logic [CW-1:0] iss_nxt;
  logic [OW-1:0] ost_cnt, ost_nxt;
  logic          fifo_empty, fifo_full_unused;
  burst_t        push_b, head;

  assign ar_hs   = arvalid_q & axi_mst_arready;
  assign r_hs    = axi_mst_rvalid & axi_mst_rready;
  assign pop     = r_hs & axi_mst_rlast & ~fifo_empty;
  assign iss_nxt = iss_cnt_q + CW'(ar_hs);
  assign ost_nxt = ost_cnt + OW'(ar_hs) - OW'(pop);

  // Expected-burst bundle captured at AR handshake.
  always_comb begin
    push_b     = '0;
    push_b.id  = arid_q;
    push_b.len = arlen_q;
`ifdef EASYAXI_RD_DATA_CHK_EN
    push_b.addr = araddr_q;
`endif
  end

  easyaxi_ost_fifo #(
    .DEPTH (OST_DEPTH),
    .W     ($bits(burst_t))
  ) u_ost_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ar_hs),
    .din   (push_b),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full_unused),
    .empty (fifo_empty),
    .cnt   (ost_cnt)
  );

  // Run-level FSM and completion count.
  always_comb begin
    state_d   = state_q;
    cmp_cnt_d = cmp_cnt_q + CW'(pop);
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_RUN;
      ST_RUN:  if (pop && cmp_cnt_q == CW'(REQ_NUM - 1)) state_d = ST_DONE;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // AR request: hold while stalled, otherwise look one handshake ahead.
  always_comb begin
    issue_ok  = (state_q == ST_RUN) && enable &&
                (iss_nxt < CW'(REQ_NUM)) &&
                (ost_nxt < OW'(OST_DEPTH));
    iss_cnt_d = iss_nxt;
    arvalid_d = arvalid_q;
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    if (!arvalid_q || axi_mst_arready) begin
      arvalid_d = issue_ok;
      if (issue_ok) begin
        arid_d    = ID_W'(iss_nxt);
        araddr_d  = ADDR_W'(iss_nxt) << 6;
        arlen_d   = LEN_W'(iss_nxt) & LEN_W'(7);
        arsize_d  = SIZE_4B;
        arburst_d = BURST_INCR;
      end
    end
  end

`ifndef EASYAXI_RD_DATA_CHK_EN
  logic unused_rdata;
  assign unused_rdata = ^axi_mst_rdata;
`endif

  // R beat checking against the FIFO head.
  always_comb begin
    bad        = 1'b0;
    beat_d     = beat_q;
    rerr_cnt_d = rerr_cnt_q;
    if (r_hs) begin
      beat_d = axi_mst_rlast ? '0 : beat_q + LEN_W'(1);
      if (fifo_empty) begin
        bad = 1'b1;
      end else begin
        if (axi_mst_rid != head.id) bad = 1'b1;
        if (axi_mst_rlast && beat_q != head.len) bad = 1'b1;
        if (!axi_mst_rlast && beat_q == head.len) bad = 1'b1;
`ifdef EASYAXI_RD_DATA_CHK_EN
        if (axi_mst_rdata != beat_data(head, beat_q)) bad = 1'b1;
`endif
      end
      if (axi_mst_rresp != RESP_OKAY) begin
        bad = 1'b1;
        if (rerr_cnt_q != 8'hFF) rerr_cnt_d = rerr_cnt_q + 8'd1;
      end
    end
    err_d = err_q | bad;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      iss_cnt_q  <= '0;
      cmp_cnt_q  <= '0;
      beat_q     <= '0;
      arvalid_q  <= 1'b0;
      arid_q     <= '0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      arsize_q   <= '0;
      arburst_q  <= '0;
      err_q      <= 1'b0;
      rerr_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      iss_cnt_q  <= iss_cnt_d;
      cmp_cnt_q  <= cmp_cnt_d;
      beat_q     <= beat_d;
      arvalid_q  <= arvalid_d;
      arid_q     <= arid_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      arsize_q   <= arsize_d;
      arburst_q  <= arburst_d;
      err_q      <= err_d;
      rerr_cnt_q <= rerr_cnt_d;
    end
  end

  assign axi_mst_arvalid = arvalid_q;
  assign axi_mst_arid    = arid_q;
  assign axi_mst_araddr  = araddr_q;
  assign axi_mst_arlen   = arlen_q;
  assign axi_mst_arsize  = arsize_q;
  assign axi_mst_arburst = arburst_q;
  assign axi_mst_rready  = (state_q != ST_IDLE);
  assign rd_done         = (state_q == ST_DONE);
  assign rd_err          = err_q;
  assign rd_resp_err_cnt = rerr_cnt_q;
endmodule

// File: tb/tb_easyaxi_rd_mst.sv
// Directed bench for easyaxi_rd_mst: scenario table plus hand sequences.
// A small slave model answers AR requests with correctly formed R bursts.
`timescale 1ns/1ps
module tb_easyaxi_rd_mst;
  import easyaxi_rd_mst_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               enable = 1'b0;
  logic               arvalid;
  logic               arready = 1'b0;
  logic [ID_W-1:0]    arid;
  logic [ADDR_W-1:0]  araddr;
  logic [LEN_W-1:0]   arlen;
  logic [SIZE_W-1:0]  arsize;
  logic [BURST_W-1:0] arburst;
  logic               rvalid = 1'b0;
  logic               rready;
  logic [ID_W-1:0]    rid = '0;
  logic [DATA_W-1:0]  rdata = '0;
  logic [RESP_W-1:0]  rresp = '0;
  logic               rlast = 1'b0;
  logic               rd_done;
  logic               rd_err;
  logic [7:0]         rd_resp_err_cnt;

  always #5 clk = ~clk;

  easyaxi_rd_mst #(.OST_DEPTH(4), .REQ_NUM(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .axi_mst_arvalid (arvalid),
    .axi_mst_arready (arready),
    .axi_mst_arid    (arid),
    .axi_mst_araddr  (araddr),
    .axi_mst_arlen   (arlen),
    .axi_mst_arsize  (arsize),
    .axi_mst_arburst (arburst),
    .axi_mst_rvalid  (rvalid),
    .axi_mst_rready  (rready),
    .axi_mst_rid     (rid),
    .axi_mst_rdata   (rdata),
    .axi_mst_rresp   (rresp),
    .axi_mst_rlast   (rlast),
    .rd_done         (rd_done),
    .rd_err          (rd_err),
    .rd_resp_err_cnt (rd_resp_err_cnt)
  );

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] addr;
  } bst_t;

  typedef struct {
    string       name;
    bit          swap;
    bit          thr;
    logic [63:0] mask;
    bit          exp_err;
    int          exp_cnt;
  } scen_t;

  bst_t        arq[$];
  int          cur_sel, beat, gbeat, acc, cmp, cyc;
  bit          ar_rdy, ar_thr, r_en, swap_pend, swap_mode, chk_err_pend;
  logic [63:0] err_mask;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after a falling edge: sets inputs for the next rising
  // edge and books the handshakes that edge will complete.
  task automatic drive();
    bst_t             b;
    logic [DATA_W-1:0] d;
    bit               ar_go;
    cyc++;
    if (chk_err_pend) begin
      chk("swap_err_next_cycle", rd_err, 1);
      chk_err_pend = 0;
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rid    = '0;
    rdata  = '0;
    rresp  = RESP_OKAY;
    if (cur_sel < 0 && r_en) begin
      if (swap_pend && arq.size() >= 2) begin
        cur_sel   = 1;
        swap_pend = 0;
      end else if (!swap_pend && arq.size() >= 1) begin
        cur_sel = 0;
      end
    end
    if (cur_sel >= 0) begin
      b      = arq[cur_sel];
      rvalid = 1'b1;
      rid    = b.id;
      rlast  = (beat == int'(b.len));
      d      = '0;
      d[ADDR_W-1:0]   = b.addr + ADDR_W'(beat * 4);
      d[ADDR_W+:ID_W] = b.id;
      rdata  = d;
      if (gbeat < 64 && err_mask[gbeat]) rresp = `AXI_RESP_SLVERR;
      if (rready) begin
        if (swap_mode && gbeat == 0) begin
          chk("swap_err_before", rd_err, 0);
          chk_err_pend = 1;
        end
        gbeat++;
        if (rlast) begin
          arq.delete(cur_sel);
          cur_sel = -1;
          beat    = 0;
          cmp++;
        end else begin
          beat++;
        end
      end
    end
    ar_go   = ar_rdy && (!ar_thr || cyc[0]);
    arready = ar_go;
    if (arvalid && ar_go) begin
      chk("arid", arid, ID_W'(acc));
      chk("araddr", araddr, ADDR_W'(acc * 64));
      chk("arlen", arlen, LEN_W'(acc % 8));
      chk("arsize", arsize, 2);
      chk("arburst", arburst, `AXI_BURST_INCR);
      b.id   = arid;
      b.len  = arlen;
      b.addr = araddr;
      arq.push_back(b);
      acc++;
    end
  endtask

  task automatic clear_model();
    arq.delete();
    cur_sel = -1; beat = 0; gbeat = 0; acc = 0; cmp = 0; cyc = 0;
    ar_rdy = 1; ar_thr = 0; r_en = 1;
    swap_pend = 0; swap_mode = 0; chk_err_pend = 0; err_mask = '0;
    arready = 0; rvalid = 0; rlast = 0; rid = '0; rdata = '0;
    rresp = RESP_OKAY;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string t);
    chk({t, "_arvalid"}, arvalid, 0);
    chk({t, "_arid"}, arid, 0);
    chk({t, "_araddr"}, araddr, 0);
    chk({t, "_arlen"}, arlen, 0);
    chk({t, "_arsize"}, arsize, 0);
    chk({t, "_arburst"}, arburst, 0);
    chk({t, "_rready"}, rready, 0);
    chk({t, "_done"}, rd_done, 0);
    chk({t, "_err"}, rd_err, 0);
    chk({t, "_cnt"}, rd_resp_err_cnt, 0);
  endtask

  task automatic run_to_done(input string t);
    int n;
    n = 0;
    while (!rd_done && n < 600) begin
      @(negedge clk);
      if (!rd_done) drive();
      n++;
    end
    rvalid  = 1'b0;
    rlast   = 1'b0;
    arready = 1'b0;
    chk({t, "_done"}, rd_done, 1);
    chk({t, "_bursts"}, cmp, 8);
  endtask

  scen_t tbl[5];

  initial begin
    bit found;
    tbl[0] = '{"plain",   0, 0, 64'h0,           0, 0};
    tbl[1] = '{"slverr3", 0, 0, 64'h418,         1, 3};
    tbl[2] = '{"swap",    1, 0, 64'h0,           1, 0};
    tbl[3] = '{"lasterr", 0, 0, 64'h8_0000_0000, 1, 1};
    tbl[4] = '{"throttle",0, 1, 64'h0,           0, 0};

    // Reset state and first-request latency with AR stalled.
    rst_n = 1'b0;
    clear_model();
    #12;
    chk_reset_vals("rst");
    do_reset();
    chk_reset_vals("idle");
    ar_rdy = 0;
    enable = 1'b1;
    @(negedge clk);
    chk("lat_run_cycle_arvalid", arvalid, 0);
    chk("lat_rready", rready, 1);
    @(negedge clk);
    chk("lat_arvalid", arvalid, 1);
    for (int i = 0; i < 10; i++) begin
      enable = (i < 3 || i > 6);
      drive();
      @(negedge clk);
      chk("stall_arvalid", arvalid, 1);
      chk("stall_arid", arid, 0);
      chk("stall_araddr", araddr, 0);
      chk("stall_arlen", arlen, 0);
    end
    ar_rdy = 1;
    drive();
    ar_rdy = 0;
    @(negedge clk);
    drive();
    chk("one_hs_count", acc, 1);
    chk("one_hs_next_arid", arid, 1);
    chk("one_hs_arvalid", arvalid, 1);
    ar_rdy = 1;
    run_to_done("stall");
    chk("stall_err", rd_err, 0);

    // Outstanding limit: hold R until four bursts are in flight.
    do_reset();
    r_en   = 0;
    enable = 1'b1;
    for (int n = 0; n < 30 && acc < 4; n++) begin
      @(negedge clk);
      drive();
    end
    chk("ost_four_accepted", acc, 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ost_full_arvalid", arvalid, 0);
      drive();
    end
    r_en = 1;
    @(negedge clk);
    drive();
    chk("ost_pop_pending_arvalid", arvalid, 0);
    @(negedge clk);
    chk("ost_after_pop_arvalid", arvalid, 1);
    drive();
    run_to_done("ost");
    chk("ost_err", rd_err, 0);

    // Scenario table.
    for (int s = 0; s < 5; s++) begin
      do_reset();
      swap_pend = tbl[s].swap;
      swap_mode = tbl[s].swap;
      ar_thr    = tbl[s].thr;
      err_mask  = tbl[s].mask;
      enable    = 1'b1;
      run_to_done(tbl[s].name);
      @(negedge clk);
      chk({tbl[s].name, "_err"}, rd_err, tbl[s].exp_err);
      chk({tbl[s].name, "_rcnt"}, rd_resp_err_cnt, tbl[s].exp_cnt);
      chk({tbl[s].name, "_arvalid"}, arvalid, 0);
      chk({tbl[s].name, "_done_hold"}, rd_done, 1);
    end

    // Reset during beat 3 of the fifth burst, then a clean rerun.
    do_reset();
    enable = 1'b1;
    found  = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (cur_sel >= 0 && arq[cur_sel].id == 4 && beat == 2) begin
        found = 1;
        break;
      end
      drive();
    end
    chk("midrst_point_found", found, 1);
    #1;
    rst_n  = 1'b0;
    enable = 1'b0;
    clear_model();
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("midrst_rel");
    enable = 1'b1;
    run_to_done("rerun");
    @(negedge clk);
    chk("rerun_err", rd_err, 0);
    chk("rerun_rcnt", rd_resp_err_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
